control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port CLK input 1 -- single system clock; state register updates on rising edge.
REQ-002 SHALL have port Reset input 1 -- asynchronous, active-low reset; Reset==0 forces state IF immediately.
REQ-003 SHALL have port opcode input 6 -- instruction bits [31:26] from instruction register.
REQ-004 SHALL have port zero input 1 -- ALU result-equals-zero flag.
REQ-005 SHALL have port PCWre output 1 -- PC write enable to program counter.
REQ-006 SHALL have port PCSrc output 2 -- next-PC select: 00 PC+4, 01 branch (PC+4+imm<<2), 10 jump target; 11 never driven.
REQ-007 SHALL have port IRWre output 1 -- instruction register load enable.
REQ-008 SHALL have ports ALUSrcB, RegDst, RegWre, ExtSel, DBDataSrc, MemRead, MemWrite, output 1 each -- datapath selects and enables.
REQ-009 SHALL have port ALUOp output 3 -- 000 add, 001 sub.
REQ-010 SHALL have port state output 3 -- current FSM state, for debug.

Function
REQ-011 SHALL implement Moore-style FSM with states IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=101; codes 110/111 SHALL transition to IF.
REQ-012 SHALL decode opcodes: add 000000, sub 000001, addi 000010, lw 110000, sw 110001, beq 110100, j 111000, halt 111111; any other = nop.
REQ-013 SHALL transition IF->ID unconditionally.
REQ-014 SHALL transition from ID: add/sub/addi/lw/sw/beq->EXE; j->IF; nop->IF; halt->HALT.
REQ-015 SHALL transition from EXE: add/sub/addi->WB; lw/sw->MEM; beq->IF.
REQ-016 SHALL transition from MEM: lw->WB; sw->IF; from WB->IF; HALT->HALT until reset.
REQ-017 SHALL assert PCWre for exactly one cycle, in the final state of each instruction: ID for j/nop, EXE for beq, MEM for sw, WB for add/sub/addi/lw; never in IF or HALT.
REQ-018 SHALL drive PCSrc=10 in ID when opcode=j; PCSrc=01 in EXE when opcode=beq and zero=1; otherwise 00.
REQ-019 SHALL assert IRWre only in IF.
REQ-020 SHALL drive ALUOp=001 in EXE for sub and beq, else 000.
REQ-021 SHALL assert ALUSrcB=1 and ExtSel=1 for addi/lw/sw in EXE; ExtSel=1 for beq in EXE.
REQ-022 SHALL assert MemRead in MEM for lw only; MemWrite in MEM for sw only, one cycle.
REQ-023 SHALL assert RegWre only in WB; RegDst=1 for add/sub, 0 for addi/lw; DBDataSrc=1 for lw only.
REQ-024 SHALL derive all outputs combinationally from state and opcode (plus zero for PCSrc), no output glitch dependency on other inputs.
REQ-025 SHALL keep opcode decode valid from ID onward (IR stable because IRWre low outside IF).

Reset
REQ-026 SHALL on Reset==0, asynchronously set state=IF; outputs then: IRWre=1, PCWre=0, PCSrc=00, ALUOp=000, all other outputs 0.
REQ-027 SHALL, on Reset asserted mid-instruction (any state incl. HALT), abandon instruction with no further PCWre, RegWre or MemWrite pulse.
REQ-028 SHALL resume with IF->ID on first rising CLK edge after Reset returns high.

Verification
REQ-029 Reset low then release, opcode=000000 -> states IF,ID,EXE,WB,IF; PCWre=1 and RegWre=1, RegDst=1 only in WB.
REQ-030 opcode=110000 (lw) -> IF,ID,EXE,MEM,WB,IF; MemRead=1 in MEM; DBDataSrc=1, RegWre=1, PCWre=1 in WB; total 5 cycles.
REQ-031 opcode=110100 (beq), zero=1 -> EXE cycle PCSrc=01, ALUOp=001, PCWre=1; repeat zero=0 -> PCSrc=00, PCWre=1.
REQ-032 opcode=111000 (j) -> ID cycle PCSrc=10, PCWre=1, next state IF; opcode=101010 (nop) -> ID PCSrc=00, PCWre=1.
REQ-033 opcode=111111 -> HALT held 10 cycles with PCWre=0, all enables 0; Reset pulse -> state=000, IRWre=1.
REQ-034 opcode=110001 (sw), Reset dropped in MEM -> MemWrite deasserts immediately, state=IF, no PCWre pulse.

Source files
------------

// File: rtl/control_unit.sv
// Multicycle controller for a small MIPS subset: Moore FSM walking IF/ID/EXE/MEM/WB, plus HALT.
// One state per CLK edge; outputs are purely combinational from state, opcode and zero (no handshake).
module control_unit (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       PCWre,
  output logic [1:0] PCSrc,
  output logic       IRWre,
  output logic       ALUSrcB,
  output logic       RegDst,
  output logic       RegWre,
  output logic       ExtSel,
  output logic       DBDataSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic [2:0] ALUOp,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b101
  } state_t;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_LW   = 6'b110000;
  localparam logic [5:0] OP_SW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  state_t state_q;
  state_t state_d;

  logic is_add;
  logic is_sub;
  logic is_addi;
  logic is_lw;
  logic is_sw;
  logic is_beq;
  logic is_j;
  logic is_halt;
  logic is_rtype;
  logic is_imm;

  // Opcode is held by the IR from ID onward, so decode can be used directly.
  always_comb begin
    is_add   = (opcode == OP_ADD);
    is_sub   = (opcode == OP_SUB);
    is_addi  = (opcode == OP_ADDI);
    is_lw    = (opcode == OP_LW);
    is_sw    = (opcode == OP_SW);
    is_beq   = (opcode == OP_BEQ);
    is_j     = (opcode == OP_J);
    is_halt  = (opcode == OP_HALT);
    is_rtype = is_add | is_sub;
    is_imm   = is_addi | is_lw | is_sw;
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = S_IF;
    PCWre     = 1'b0;
    PCSrc     = PC_SEQ;
    IRWre     = 1'b0;
    ALUSrcB   = 1'b0;
    RegDst    = 1'b0;
    RegWre    = 1'b0;
    ExtSel    = 1'b0;
    DBDataSrc = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    ALUOp     = 3'b000;

    case (state_q)
      S_IF: begin
        IRWre   = 1'b1;
        state_d = S_ID;
      end

      S_ID: begin
        if (is_halt) begin
          state_d = S_HALT;
        end else if (is_rtype | is_imm | is_beq) begin
          state_d = S_EXE;
        end else begin
          // j and nop both retire here
          PCWre   = 1'b1;
          PCSrc   = is_j ? PC_JUMP : PC_SEQ;
          state_d = S_IF;
        end
      end

      S_EXE: begin
        ALUOp   = (is_sub | is_beq) ? 3'b001 : 3'b000;
        ALUSrcB = is_imm;
        ExtSel  = is_imm | is_beq;
        if (is_beq) begin
          PCWre   = 1'b1;
          PCSrc   = zero ? PC_BRANCH : PC_SEQ;
          state_d = S_IF;
        end else if (is_lw | is_sw) begin
          state_d = S_MEM;
        end else if (is_rtype | is_addi) begin
          state_d = S_WB;
        end else begin
          state_d = S_IF;
        end
      end

      S_MEM: begin
        MemRead  = is_lw;
        MemWrite = is_sw;
        if (is_lw) begin
          state_d = S_WB;
        end else begin
          PCWre   = is_sw;
          state_d = S_IF;
        end
      end

      S_WB: begin
        PCWre     = 1'b1;
        RegWre    = 1'b1;
        RegDst    = is_rtype;
        DBDataSrc = is_lw;
        state_d   = S_IF;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_IF;
      end
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed literal checks, then randomized instruction stream vs path-table model.
module tb_control_unit;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_LW   = 6'b110000;
  localparam logic [5:0] OP_SW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] OP_NOP  = 6'b101010;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic [5:0] opcode = OP_ADD;
  logic       zero = 1'b0;
  logic       PCWre;
  logic [1:0] PCSrc;
  logic       IRWre;
  logic       ALUSrcB;
  logic       RegDst;
  logic       RegWre;
  logic       ExtSel;
  logic       DBDataSrc;
  logic       MemRead;
  logic       MemWrite;
  logic [2:0] ALUOp;
  logic [2:0] state;

  control_unit dut (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero),
    .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .ALUSrcB(ALUSrcB),
    .RegDst(RegDst), .RegWre(RegWre), .ExtSel(ExtSel), .DBDataSrc(DBDataSrc),
    .MemRead(MemRead), .MemWrite(MemWrite), .ALUOp(ALUOp), .state(state)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;
  bit check_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", nm, act, exp, $time);
  endtask

  // Model: each instruction is the list of states it visits; the last one retires it.
  int m_path[$];
  int m_pos = 0;

  function automatic int m_state();
    return m_path[m_pos];
  endfunction

  task automatic build_path(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDI: m_path = '{0, 1, 2, 4};
      OP_LW:                   m_path = '{0, 1, 2, 3, 4};
      OP_SW:                   m_path = '{0, 1, 2, 3};
      OP_BEQ:                  m_path = '{0, 1, 2};
      OP_HALT:                 m_path = '{0, 1, 5};
      default:                 m_path = '{0, 1};
    endcase
  endtask

  task automatic advance();
    if (!Reset) m_pos = 0;
    else if (m_pos == 0) begin
      build_path(opcode);
      m_pos = 1;
    end else if (m_pos == m_path.size() - 1) begin
      if (m_state() != 5) m_pos = 0;
    end else m_pos++;
  endtask

  task automatic model_reset();
    m_pos = 0;
  endtask

  function automatic logic [16:0] exp_vec(input int st, input logic [5:0] op, input logic z, input bit last);
    logic       pcw, irw, asb, rdst, rw, ext, dbs, mr, mw;
    logic [1:0] src;
    logic [2:0] aop;
    bit r_t, i_t;
    r_t  = (op == OP_ADD) || (op == OP_SUB);
    i_t  = (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
    pcw  = last && st != 0 && st != 5;
    src  = (st == 1 && op == OP_J) ? 2'b10 : (st == 2 && op == OP_BEQ && z) ? 2'b01 : 2'b00;
    irw  = (st == 0);
    aop  = (st == 2 && (op == OP_SUB || op == OP_BEQ)) ? 3'd1 : 3'd0;
    asb  = (st == 2) && i_t;
    ext  = (st == 2) && (i_t || op == OP_BEQ);
    mr   = (st == 3) && op == OP_LW;
    mw   = (st == 3) && op == OP_SW;
    rw   = (st == 4);
    rdst = (st == 4) && r_t;
    dbs  = (st == 4) && op == OP_LW;
    return {pcw, src, irw, asb, rdst, rw, ext, dbs, mr, mw, aop, 3'(st)};
  endfunction

  always @(negedge CLK) begin
    if (check_en) begin
      chk($sformatf("outputs st%0d op%06b", m_state(), opcode),
          int'({PCWre, PCSrc, IRWre, ALUSrcB, RegDst, RegWre, ExtSel, DBDataSrc,
                MemRead, MemWrite, ALUOp, state}),
          int'(exp_vec(m_state(), opcode, zero,
                       (m_pos != 0) && (m_pos == m_path.size() - 1))));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    advance();
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 9))
      0: return OP_ADD;
      1: return OP_SUB;
      2: return OP_ADDI;
      3: return OP_LW;
      4: return OP_SW;
      5: return OP_BEQ;
      6: return OP_J;
      7: return ($urandom_range(0, 3) == 0) ? OP_HALT : OP_NOP;
      default: return 6'($urandom);
    endcase
  endfunction

  initial begin
    m_path = '{0, 1};
    #1 Reset = 1'b0;
    #2;
    chk("rst_state", state, 0);
    chk("rst_irwre", IRWre, 1);
    chk("rst_pcwre", PCWre, 0);
    chk("rst_others", {PCSrc, ALUOp, ALUSrcB, RegDst, RegWre, ExtSel, DBDataSrc, MemRead, MemWrite}, 0);
    check_en = 1'b1;
    tick();
    #1 Reset = 1'b1;

    // add: IF ID EXE WB IF
    tick(); chk("add_id", state, 1);
    tick(); chk("add_exe", state, 2); chk("add_exe_pcwre", PCWre, 0);
    tick(); chk("add_wb", state, 4);
    chk("add_wb_ctl", {PCWre, RegWre, RegDst}, 3'b111);
    tick(); chk("add_back_if", state, 0);

    // lw: five cycles
    opcode = OP_LW;
    tick(); tick();
    tick(); chk("lw_mem", state, 3); chk("lw_memread", MemRead, 1);
    tick(); chk("lw_wb", {DBDataSrc, RegWre, PCWre}, 3'b111);
    tick(); chk("lw_back_if", state, 0);

    // beq taken then not taken
    opcode = OP_BEQ; zero = 1'b1;
    tick(); tick();
    chk("beq_t_ctl", {PCSrc, ALUOp, PCWre}, {2'b01, 3'b001, 1'b1});
    tick(); zero = 1'b0;
    tick(); tick();
    chk("beq_nt_ctl", {PCSrc, PCWre}, {2'b00, 1'b1});
    tick();

    // j and nop retire in ID
    opcode = OP_J;
    tick(); chk("j_id", {PCSrc, PCWre}, {2'b10, 1'b1});
    tick(); chk("j_next_if", state, 0);
    opcode = OP_NOP;
    tick(); chk("nop_id", {PCSrc, PCWre}, {2'b00, 1'b1});
    tick();

    // halt held, then reset pulse
    opcode = OP_HALT;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("halt_hold", {state, PCWre, RegWre, MemWrite, MemRead, IRWre}, {3'b101, 5'b0});
    end
    #1 Reset = 1'b0; model_reset();
    #1 chk("halt_rst", {state, IRWre}, {3'b000, 1'b1});
    tick();
    #1 Reset = 1'b1;

    // sw interrupted in MEM
    opcode = OP_SW;
    tick(); tick();
    tick(); chk("sw_mem_write", MemWrite, 1);
    #1 Reset = 1'b0; model_reset();
    #1 chk("sw_rst_abort", {MemWrite, PCWre, state}, {2'b00, 3'b000});
    tick();
    #1 Reset = 1'b1;
    tick(); chk("resume_id", state, 1);

    // randomized instruction stream with occasional async resets
    for (int c = 0; c < 4000; c++) begin
      tick();
      zero = 1'($urandom);
      if (m_pos == 0) opcode = pick_op();
      if (Reset && $urandom_range(0, 39) == 0) begin
        #1 Reset = 1'b0; model_reset();
      end else if (!Reset && $urandom_range(0, 1) == 0) begin
        #1 Reset = 1'b1;
      end
    end

    @(posedge CLK);
    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
